// File: rtl/resource_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : resource_arbiter
// Brief    : Round-robin sharing of one in-order resource between NUM_REQ
//            requesters, with a tag FIFO that routes responses back home.
// Revision : 1.0 - initial release
// ============================================================================
module resource_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ*DATA_W-1:0]        req_data,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_flush,
    output logic [NUM_REQ-1:0]               req_stall,
    output logic [DATA_W-1:0]                out_data_to_resource,
    output logic                             out_valid_to_resource,
    output logic                             out_flush_to_resource,
    input  logic                             in_stall_from_resource,
    input  logic [DATA_W-1:0]                in_data_from_resource,
    input  logic                             in_valid_from_resource,
    output logic                             out_stall_to_resource,
    output logic [DATA_W-1:0]                rsp_data,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_stall,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_cnt,
    output logic                             err_orphan
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_out_flush;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_tags [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err_orphan;

    logic [DATA_W-1:0] w_req_data [NUM_REQ];
    logic [IDX_W-1:0]  w_cand     [NUM_REQ];
    logic [NUM_REQ-1:0] w_requesting;
    logic [NUM_REQ-1:0] w_eligible;
    logic              w_issue_free;
    logic              w_full;
    logic              w_empty;
    logic              w_grant_any;
    logic [IDX_W-1:0]  w_grant_idx;
    logic [IDX_W-1:0]  w_head;
    logic              w_push;
    logic              w_pop;

    assign w_requesting = req_valid | req_flush;
    assign w_issue_free = !r_out_valid || !in_stall_from_resource;
    assign w_full       = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty      = (r_count == '0);

    // Flush-only beats carry no tag, so only data beats are gated by a full FIFO.
    assign w_eligible = w_issue_free
                      ? ((req_flush & ~req_valid) | (req_valid & {NUM_REQ{!w_full}}))
                      : '0;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            assign w_req_data[i] = req_data[i*DATA_W +: DATA_W];
            assign w_cand[i]     = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            assign req_stall[i]  = w_requesting[i]
                                 & ~(w_grant_any & (w_grant_idx == IDX_W'(i)));
        end
    endgenerate

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_any && w_eligible[w_cand[k]]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand[k];
            end
        end
    end

    assign w_push = w_grant_any & req_valid[w_grant_idx];
    assign w_head = r_tags[r_rd_ptr];
    assign w_pop  = !w_empty && in_valid_from_resource && !rsp_stall[w_head];

    always_comb begin
        rsp_valid = '0;
        if (!w_empty) begin
            rsp_valid[w_head] = in_valid_from_resource;
        end
    end

    assign out_stall_to_resource = !w_empty && rsp_stall[w_head];
    assign rsp_data              = in_data_from_resource;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_flush <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_grant_any) begin
            r_out_data  <= w_req_data[w_grant_idx];
            r_out_valid <= req_valid[w_grant_idx];
            r_out_flush <= req_flush[w_grant_idx];
            r_rr_ptr    <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
        end else if (w_issue_free) begin
            r_out_valid <= 1'b0;
            r_out_flush <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wr_ptr] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_empty && in_valid_from_resource) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign out_data_to_resource  = r_out_data;
    assign out_valid_to_resource = r_out_valid;
    assign out_flush_to_resource = r_out_flush;
    assign outstanding_cnt       = r_count;
    assign err_orphan            = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_resource_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_resource_arbiter
// Brief    : Directed self-checking bench for resource_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resource_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_flush;
    logic [N-1:0]   req_stall;
    logic [W-1:0]   out_data_to_resource;
    logic           out_valid_to_resource;
    logic           out_flush_to_resource;
    logic           in_stall_from_resource;
    logic [W-1:0]   in_data_from_resource;
    logic           in_valid_from_resource;
    logic           out_stall_to_resource;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_stall;
    logic [2:0]     outstanding_cnt;
    logic           err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    resource_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_OUTSTANDING(4)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_data               (req_data),
        .req_valid              (req_valid),
        .req_flush              (req_flush),
        .req_stall              (req_stall),
        .out_data_to_resource   (out_data_to_resource),
        .out_valid_to_resource  (out_valid_to_resource),
        .out_flush_to_resource  (out_flush_to_resource),
        .in_stall_from_resource (in_stall_from_resource),
        .in_data_from_resource  (in_data_from_resource),
        .in_valid_from_resource (in_valid_from_resource),
        .out_stall_to_resource  (out_stall_to_resource),
        .rsp_data               (rsp_data),
        .rsp_valid              (rsp_valid),
        .rsp_stall              (rsp_stall),
        .outstanding_cnt        (outstanding_cnt),
        .err_orphan             (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (out_valid_to_resource !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid_to_resource); end
        n_cmp++; if (out_flush_to_resource !== 1'b0) begin n_err++; $display("FAIL rst_out_flush got %b exp 0", out_flush_to_resource); end
        n_cmp++; if (out_data_to_resource !== 32'h0) begin n_err++; $display("FAIL rst_out_data got %h exp 0", out_data_to_resource); end
        n_cmp++; if (outstanding_cnt !== 3'd0) begin n_err++; $display("FAIL rst_cnt got %0d exp 0", outstanding_cnt); end
        n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL rst_orphan got %b exp 0", err_orphan); end
        n_cmp++; if (req_stall !== 4'b0000) begin n_err++; $display("FAIL rst_req_stall got %b exp 0000", req_stall); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_stall;
        logic [N-1:0] exp_rsp;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA000_0000 + 32'(i);
        for (int k = 0; k < 12; k++) begin
            tick();
            req_valid              = (k < 8) ? 4'hF : 4'h0;
            in_valid_from_resource = (k >= 2 && k <= 9);
            in_data_from_resource  = 32'hA000_0000 + 32'((k + 2) % 4);
            @(negedge clk);
            exp_stall = (k < 8) ? (4'hF & ~(4'b0001 << (k % 4))) : 4'h0;
            exp_rsp   = (k >= 2 && k <= 9) ? (4'b0001 << ((k + 2) % 4)) : 4'h0;
            n_cmp++; if (req_stall !== exp_stall) begin n_err++; $display("FAIL rr_stall k=%0d got %b exp %b", k, req_stall, exp_stall); end
            n_cmp++; if (out_valid_to_resource !== (k >= 1 && k <= 8)) begin n_err++; $display("FAIL rr_out_valid k=%0d got %b", k, out_valid_to_resource); end
            if (k >= 1 && k <= 8) begin
                n_cmp++; if (out_data_to_resource !== 32'hA000_0000 + 32'((k - 1) % 4)) begin n_err++; $display("FAIL rr_out_data k=%0d got %h exp %h", k, out_data_to_resource, 32'hA000_0000 + 32'((k - 1) % 4)); end
            end
            n_cmp++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL rr_rsp_valid k=%0d got %b exp %b", k, rsp_valid, exp_rsp); end
            if (k >= 2 && k <= 9) begin
                n_cmp++; if (rsp_data !== 32'hA000_0000 + 32'((k + 2) % 4)) begin n_err++; $display("FAIL rr_rsp_data k=%0d got %h", k, rsp_data); end
            end
        end
        n_cmp++; if (outstanding_cnt !== 3'd0) begin n_err++; $display("FAIL rr_cnt_end got %0d exp 0", outstanding_cnt); end
        n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL rr_orphan got %b exp 0", err_orphan); end
    endtask

    task automatic test_fifo_full;
        int b;
        int cnt_tab [13] = '{0, 1, 2, 3, 4, 4, 3, 4, 4, 3, 2, 1, 0};
        logic [N-1:0] exp_stall;
        b = 0;
        for (int c = 0; c < 13; c++) begin
            tick();
            req_valid              = (c <= 7) ? 4'b0100 : 4'b0000;
            req_data[2*W +: W]     = 32'h2000_0000 + 32'(b);
            in_valid_from_resource = (c == 5) || (c >= 8 && c <= 11);
            in_data_from_resource  = 32'h5000_0000 + 32'(c);
            @(negedge clk);
            exp_stall = (c == 4 || c == 5 || c == 7) ? 4'b0100 : 4'b0000;
            n_cmp++; if (req_stall !== exp_stall) begin n_err++; $display("FAIL full_stall c=%0d got %b exp %b", c, req_stall, exp_stall); end
            n_cmp++; if (outstanding_cnt !== 3'(cnt_tab[c])) begin n_err++; $display("FAIL full_cnt c=%0d got %0d exp %0d", c, outstanding_cnt, cnt_tab[c]); end
            if (in_valid_from_resource) begin
                n_cmp++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL full_rsp_valid c=%0d got %b exp 0100", c, rsp_valid); end
            end
            if (c == 7) begin
                n_cmp++; if (out_valid_to_resource !== 1'b1 || out_data_to_resource !== 32'h2000_0004) begin n_err++; $display("FAIL full_reissue got %b/%h exp 1/20000004", out_valid_to_resource, out_data_to_resource); end
            end
            if (req_valid[2] && !req_stall[2]) b++;
        end
    endtask

    task automatic test_issue_stall;
        logic [N-1:0] stall_tab [7] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
        for (int s = 0; s < 7; s++) begin
            tick();
            req_valid              = (s <= 4) ? 4'b0011 : (s == 5) ? 4'b0001 : 4'b0000;
            req_data[0*W +: W]     = (s == 0) ? 32'h0000_1234 : 32'h0000_1111;
            req_data[1*W +: W]     = 32'h0000_5678;
            in_stall_from_resource = (s >= 1 && s <= 3);
            @(negedge clk);
            n_cmp++; if (req_stall !== stall_tab[s]) begin n_err++; $display("FAIL stl_req_stall s=%0d got %b exp %b", s, req_stall, stall_tab[s]); end
            if (s >= 1 && s <= 4) begin
                n_cmp++; if (out_valid_to_resource !== 1'b1 || out_data_to_resource !== 32'h0000_1234) begin n_err++; $display("FAIL stl_hold s=%0d got %b/%h exp 1/00001234", s, out_valid_to_resource, out_data_to_resource); end
            end
        end
        n_cmp++; if (out_data_to_resource !== 32'h0000_1111 || outstanding_cnt !== 3'd3) begin n_err++; $display("FAIL stl_after got %h/%0d exp 00001111/3", out_data_to_resource, outstanding_cnt); end
        for (int s = 7; s < 11; s++) begin
            tick();
            in_valid_from_resource = (s <= 9);
            in_data_from_resource  = 32'h70 + 32'(s);
            @(negedge clk);
            if (s <= 9) begin
                n_cmp++; if (rsp_valid !== ((s == 8) ? 4'b0010 : 4'b0001)) begin n_err++; $display("FAIL stl_route s=%0d got %b", s, rsp_valid); end
            end
        end
        n_cmp++; if (outstanding_cnt !== 3'd0) begin n_err++; $display("FAIL stl_drain got %0d exp 0", outstanding_cnt); end
    endtask

    task automatic test_flush_when_full;
        for (int f = 0; f < 4; f++) begin
            tick();
            req_valid          = 4'b0001;
            req_data[0*W +: W] = 32'hF0 + 32'(f);
            @(negedge clk);
            n_cmp++; if (req_stall !== 4'b0000) begin n_err++; $display("FAIL fl_fill f=%0d got %b exp 0000", f, req_stall); end
        end
        tick();
        req_valid          = 4'b0010;
        req_flush          = 4'b1000;
        req_data[1*W +: W] = 32'h11;
        req_data[3*W +: W] = 32'h33;
        @(negedge clk);
        n_cmp++; if (req_stall !== 4'b0010) begin n_err++; $display("FAIL fl_grant got %b exp 0010", req_stall); end
        n_cmp++; if (outstanding_cnt !== 3'd4) begin n_err++; $display("FAIL fl_full got %0d exp 4", outstanding_cnt); end
        tick();
        req_valid = 4'b0000;
        req_flush = 4'b0000;
        @(negedge clk);
        n_cmp++; if (out_flush_to_resource !== 1'b1 || out_valid_to_resource !== 1'b0) begin n_err++; $display("FAIL fl_issue got flush %b valid %b exp 1/0", out_flush_to_resource, out_valid_to_resource); end
        n_cmp++; if (out_data_to_resource !== 32'h33) begin n_err++; $display("FAIL fl_data got %h exp 33", out_data_to_resource); end
        n_cmp++; if (outstanding_cnt !== 3'd4) begin n_err++; $display("FAIL fl_cnt got %0d exp 4", outstanding_cnt); end
    endtask

    task automatic test_rsp_stall;
        logic [2:0] cnt_tab [7] = '{3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int r = 0; r < 7; r++) begin
            tick();
            in_valid_from_resource = (r <= 5);
            in_data_from_resource  = 32'hD0 + 32'(r);
            rsp_stall              = (r <= 1) ? 4'b0001 : (r == 2) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            n_cmp++; if (outstanding_cnt !== cnt_tab[r]) begin n_err++; $display("FAIL rs_cnt r=%0d got %0d exp %0d", r, outstanding_cnt, cnt_tab[r]); end
            if (r <= 2) begin
                n_cmp++; if (out_stall_to_resource !== (r <= 1)) begin n_err++; $display("FAIL rs_out_stall r=%0d got %b", r, out_stall_to_resource); end
                n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'hD0 + 32'(r)) begin n_err++; $display("FAIL rs_route r=%0d got %b/%h", r, rsp_valid, rsp_data); end
            end
        end
    endtask

    task automatic test_orphan_and_reset;
        tick();
        in_valid_from_resource = 1'b1;
        in_data_from_resource  = 32'hEE;
        rsp_stall              = 4'hF;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 4'b0000 || out_stall_to_resource !== 1'b0) begin n_err++; $display("FAIL orph_route got %b/%b exp 0000/0", rsp_valid, out_stall_to_resource); end
        n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orph_early got %b exp 0", err_orphan); end
        tick();
        in_valid_from_resource = 1'b0;
        rsp_stall              = 4'h0;
        @(negedge clk);
        n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orph_flag got %b exp 1", err_orphan); end
        for (int i = 1; i < N; i++) req_data[i*W +: W] = 32'hC0 + 32'(i);
        req_data[0*W +: W] = 32'hC0;
        for (int o = 2; o < 5; o++) begin
            tick();
            req_valid = 4'b1110;
            @(negedge clk);
        end
        tick();
        req_valid = 4'b0000;
        reset     = 1'b1;
        @(negedge clk);
        n_cmp++; if (outstanding_cnt !== 3'd3) begin n_err++; $display("FAIL mid_cnt got %0d exp 3", outstanding_cnt); end
        tick();
        reset     = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        n_cmp++; if (outstanding_cnt !== 3'd0 || err_orphan !== 1'b0) begin n_err++; $display("FAIL mid_rst_state got %0d/%b exp 0/0", outstanding_cnt, err_orphan); end
        n_cmp++; if (out_valid_to_resource !== 1'b0 || out_flush_to_resource !== 1'b0 || out_data_to_resource !== 32'h0) begin n_err++; $display("FAIL mid_rst_out got %b/%b/%h exp 0/0/0", out_valid_to_resource, out_flush_to_resource, out_data_to_resource); end
        n_cmp++; if (req_stall !== 4'b1110) begin n_err++; $display("FAIL mid_rst_ptr got %b exp 1110", req_stall); end
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++; if (out_valid_to_resource !== 1'b1 || out_data_to_resource !== 32'hC0) begin n_err++; $display("FAIL mid_rst_grant got %b/%h exp 1/c0", out_valid_to_resource, out_data_to_resource); end
        n_cmp++; if (outstanding_cnt !== 3'd1) begin n_err++; $display("FAIL mid_rst_cnt got %0d exp 1", outstanding_cnt); end
    endtask

    initial begin
        reset                  = 1'b1;
        req_data               = '0;
        req_valid              = '0;
        req_flush              = '0;
        in_stall_from_resource = 1'b0;
        in_data_from_resource  = '0;
        in_valid_from_resource = 1'b0;
        rsp_stall              = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_fifo_full();
        test_issue_stall();
        test_flush_when_full();
        test_rsp_stall();
        test_orphan_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
